load_mshr: RTL
==============

# load_mshr

Miss-status holding registers between the load functional unit and the unified memory bus. Accepts block-aligned load requests (`start_load`/`Dmem_addr`) and sends them to memory as `MEM_LOAD` commands, retrying until memory accepts. Tracks outstanding transaction tags and, on a data-tag match, presents the returned block to the load FU and the data cache as a one-cycle fill (`Dmem_data_ready`, `mshr2cache_wr`). Asserts `dm_stalled` when no request can be accepted.

## Interface
- `DEPTH`, default `` `MSHR_SZ `` (4): number of MSHR entries; must be ≤15.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `start_load`  in  1  load FU requests a block read this cycle.
- `Dmem_addr`  in  `ADDR`  block address of the request; bits [2:0] are zero.
- `dm_squash`  in  1  cancels every entry still in `PENDING`.
- `start_store`  in  1  store owns the memory bus this cycle; no load command is sent.
- `mem2proc_transaction_tag`  in  4  tag for the command sent this cycle; 0 means rejected.
- `mem2proc_data_tag`  in  4  tag of the returning data; 0 means no data.
- `mem2proc_data`  in  `MEM_BLOCK`  returning block.
- `proc2mem_command`  out  `MEM_COMMAND`  `MEM_LOAD` or `MEM_NONE`.
- `proc2mem_addr`  out  `ADDR`  address of the command.
- `dm_stalled`  out  1  no free entry; `start_load` is ignored.
- `Dmem_data_ready`  out  1  fill valid (one cycle).
- `Dmem_base_addr`  out  `ADDR`  block address of the fill.
- `Dmem_load_data`  out  `MEM_BLOCK`  fill data.
- `mshr2cache_wr`  out  1  D-cache write port is used by the fill this cycle; equals `Dmem_data_ready`.

## Operation
- Per-entry state: `INVALID` → `PENDING` → `WAITING` → `INVALID`. Each entry also holds `addr` and `tag[3:0]`.
- **Allocate.** When `start_load && !dm_stalled`, the lowest-index `INVALID` entry becomes `PENDING` with `addr = Dmem_addr`.
- **Coalesce.** When coalescing is enabled and `Dmem_addr` matches a `PENDING` or `WAITING` entry, nothing is allocated.
- **Send.** When `!start_store` and any entry is `PENDING`, the lowest-index `PENDING` entry is sent.
  - Outputs: `proc2mem_command = MEM_LOAD` and `proc2mem_addr = addr`.
  - If `mem2proc_transaction_tag != 0`: the entry becomes `WAITING` and latches the tag.
  - If the tag is 0: the entry stays `PENDING` and is retried the next cycle.
- **No send.** When no entry is sent, `proc2mem_command = MEM_NONE` and `proc2mem_addr = 0`.
- **Fill.** When `mem2proc_data_tag != 0` matches a `WAITING` entry's tag:
  - The entry becomes `INVALID`.
  - Next cycle: `Dmem_data_ready = mshr2cache_wr = 1`, `Dmem_base_addr = addr`, `Dmem_load_data = mem2proc_data`.
  - A data tag with no matching entry is dropped.
- **Squash.** `dm_squash` sets every `PENDING` entry to `INVALID`, including the entry being sent that cycle (the command still goes out but its tag is not latched). `WAITING` entries complete normally, since the fill remains valid cache data.
- **Full.** `dm_stalled = 1` when no entry is `INVALID`, evaluated from current state (combinational).
- **Simultaneous events.** Allocate, send, and fill all occur in the same cycle. A fill frees its entry only at the next edge, so the freed entry cannot be reused in the same cycle.

## Timing
- Reset values:
  - All entries `INVALID`.
  - `proc2mem_command = MEM_NONE`; `proc2mem_addr = 0`.
  - `Dmem_data_ready = mshr2cache_wr = 0`; `Dmem_base_addr = 0`; `Dmem_load_data = 0`.
  - `dm_stalled = 0`.
- Request at cycle N:
  - Entry is `PENDING` at N+1 and the command is driven at N+1 (earliest).
  - Entry is `WAITING` at N+2 if accepted at N+1.
- Data tag match at cycle M: fill outputs are registered and valid at M+1 only.
- Reset mid-operation clears all entries. Later responses carrying the old tags are ignored.
- `proc2mem_*` is combinational from entry state plus `start_store`. `mem2proc_transaction_tag` is sampled in the same cycle.

## Configuration
- `MSHR_COALESCE_EN`
  - Defined: a request matching an outstanding block address is merged. No entry is allocated and no duplicate memory command is sent.
  - Undefined: every accepted request allocates its own entry, so duplicate fills may occur. The load FU tolerates these because it matches fills by address.

## Test plan
- **Reset.** Reset then idle 3 cycles → `proc2mem_command = MEM_NONE`, `dm_stalled = 0`, `Dmem_data_ready = 0`.
- **Single load.** `start_load`, `Dmem_addr = 0x100`; transaction tag 3 at N+1; data tag 3 with block `0xDEADBEEF_CAFEF00D` at N+5 → command `MEM_LOAD` to 0x100 at N+1; at N+6 `Dmem_data_ready = mshr2cache_wr = 1`, `Dmem_base_addr = 0x100`, matching data, for one cycle only.
- **Retry and store priority.** Transaction tag 0 twice, then 5; `start_store = 1` on the second attempt → command absent in the `start_store` cycle; entry `WAITING` with tag 5 after the accepting cycle; fill fires only for data tag 5.
- **Full.** Issue 4 loads to 0x0, 0x8, 0x10, 0x18 with no returns → `dm_stalled = 1`; a 5th request to 0x20 is ignored (it never appears on `proc2mem_addr`); after one fill, the 0x20 request is accepted.
- **Squash.** Request 0x40 then `dm_squash` while `PENDING` with transaction tag 0 → no later `MEM_LOAD` to 0x40; a concurrent `WAITING` entry for 0x48 still fills.
- **Coalesce.** Two requests to 0x80 in consecutive cycles → exactly one `MEM_LOAD` with `MSHR_COALESCE_EN` defined, two without.

Source files
------------

// File: rtl/load_mshr_if.sv
// Shared load-MSHR types and the unified memory-bus interface.
// master: MSHR drives command/addr and samples tags/data; slave: memory side.
`ifndef MSHR_SZ
`define MSHR_SZ 4
`endif

package load_mshr_pkg;
  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;
  typedef enum logic [1:0] {
    INVALID = 2'h0,
    PENDING = 2'h1,
    WAITING = 2'h2
  } mshr_state_e;
endpackage

interface load_mshr_if;
  import load_mshr_pkg::*;
  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  logic [3:0] mem2proc_transaction_tag;
  logic [3:0] mem2proc_data_tag;
  MEM_BLOCK   mem2proc_data;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    input  mem2proc_transaction_tag,
    input  mem2proc_data_tag,
    input  mem2proc_data
  );
  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    output mem2proc_transaction_tag,
    output mem2proc_data_tag,
    output mem2proc_data
  );
endinterface

// File: rtl/load_mshr.sv
// Load miss-status holding registers: allocate, send MEM_LOAD with retry,
// match returning data tags, and present a registered one-cycle fill.
// Ports: clock/reset (sync, active-high); FU side start_load, Dmem_addr,
// dm_squash, start_store, dm_stalled, Dmem_* fill, mshr2cache_wr; memory
// side via load_mshr_if.master. Optional macro MSHR_COALESCE_EN merges
// requests to a block address that is already outstanding.
module load_mshr
  import load_mshr_pkg::*;
#(
  parameter int DEPTH = `MSHR_SZ
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start_load,
  input  ADDR            Dmem_addr,
  input  logic           dm_squash,
  input  logic           start_store,
  load_mshr_if.master    mem,
  output logic           dm_stalled,
  output logic           Dmem_data_ready,
  output ADDR            Dmem_base_addr,
  output MEM_BLOCK       Dmem_load_data,
  output logic           mshr2cache_wr
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mshr_state_e state_q [DEPTH];
  mshr_state_e state_d [DEPTH];
  ADDR         addr_q  [DEPTH];
  ADDR         addr_d  [DEPTH];
  logic [3:0]  tag_q   [DEPTH];
  logic [3:0]  tag_d   [DEPTH];

  logic     fill_v_q, fill_v_d;
  ADDR      fill_addr_q, fill_addr_d;
  MEM_BLOCK fill_data_q, fill_data_d;

  logic [IW-1:0] free_idx, send_idx, fill_idx;
  logic          any_free, send_v, fill_v, alloc, hit;

  // Lowest-index scans: the loop runs high-to-low so the last hit wins.
  always_comb begin
    free_idx = '0;
    send_idx = '0;
    fill_idx = '0;
    any_free = 1'b0;
    send_v   = 1'b0;
    fill_v   = 1'b0;
    hit      = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == INVALID) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
      if (state_q[i] == PENDING) begin
        send_idx = IW'(i);
        send_v   = 1'b1;
      end
      if (state_q[i] == WAITING &&
          mem.mem2proc_data_tag != 4'd0 &&
          tag_q[i] == mem.mem2proc_data_tag) begin
        fill_idx = IW'(i);
        fill_v   = 1'b1;
      end
`ifdef MSHR_COALESCE_EN
      if (state_q[i] != INVALID && addr_q[i] == Dmem_addr)
        hit = 1'b1;
`endif
    end
    send_v = send_v && !start_store;
    alloc  = start_load && any_free && !hit;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      tag_d[i]   = tag_q[i];
    end
    if (send_v && mem.mem2proc_transaction_tag != 4'd0 && !dm_squash) begin
      state_d[send_idx] = WAITING;
      tag_d[send_idx]   = mem.mem2proc_transaction_tag;
    end
    if (dm_squash)
      for (int i = 0; i < DEPTH; i++)
        if (state_q[i] == PENDING)
          state_d[i] = INVALID;
    if (fill_v)
      state_d[fill_idx] = INVALID;
    // The free entry is INVALID now, so nothing above touched it.
    if (alloc) begin
      state_d[free_idx] = PENDING;
      addr_d[free_idx]  = Dmem_addr;
    end
    fill_v_d    = fill_v;
    fill_addr_d = fill_v ? addr_q[fill_idx] : fill_addr_q;
    fill_data_d = fill_v ? mem.mem2proc_data : fill_data_q;
  end

  always_comb begin
    dm_stalled           = !any_free;
    mem.proc2mem_command = send_v ? MEM_LOAD : MEM_NONE;
    mem.proc2mem_addr    = send_v ? addr_q[send_idx] : '0;
    Dmem_data_ready      = fill_v_q;
    mshr2cache_wr        = fill_v_q;
    Dmem_base_addr       = fill_addr_q;
    Dmem_load_data       = fill_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= INVALID;
        addr_q[i]  <= '0;
        tag_q[i]   <= '0;
      end
      fill_v_q    <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i]  <= addr_d[i];
        tag_q[i]   <= tag_d[i];
      end
      fill_v_q    <= fill_v_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end
endmodule
